// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC engine.
// The arctangent table is scaled so that 2^31 represents pi.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ATAN_ENTRIES = 32;

  // atan(2^-i) / pi * 2^31, i = 0..31
  localparam logic [31:0] ATAN_TABLE [ATAN_ENTRIES] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

endpackage

// File: rtl/cordic_iter_shifter.sv
// Combinational arithmetic (sign-filling) right shifter.
module cordic_iter_shifter #(
  parameter int BIT_WIDTH = 16,
  parameter int SHIFT_W   = $clog2(BIT_WIDTH + 1)
) (
  input  logic [BIT_WIDTH-1:0] data_i,
  input  logic [SHIFT_W-1:0]   shamt_i,
  output logic [BIT_WIDTH-1:0] result_o
);

  assign result_o = $unsigned($signed(data_i) >>> shamt_i);

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC: one micro-rotation per clock, rotation or vectoring mode,
// uncompensated gain, binary-angle z with 2^(BIT_WIDTH-1) = pi.
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int ITERATIONS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  input  logic                 mode_in,
  input  logic [BIT_WIDTH-1:0] x_in,
  input  logic [BIT_WIDTH-1:0] y_in,
  input  logic [BIT_WIDTH-1:0] z_in,
  output logic                 ready_out,
  output logic                 done_out,
  output logic [BIT_WIDTH-1:0] x_out,
  output logic [BIT_WIDTH-1:0] y_out,
  output logic [BIT_WIDTH-1:0] z_out
);

  localparam int CNT_W   = $clog2(ITERATIONS + 1);
  localparam int SHIFT_W = $clog2(BIT_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_I = CNT_W'(ITERATIONS);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     i_q, i_d;
  logic                 mode_q, mode_d;
  logic [BIT_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [BIT_WIDTH-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

  logic [SHIFT_W-1:0]   shamt;
  logic [4:0]           atan_idx;
  logic [BIT_WIDTH-1:0] x_shr, y_shr, atan_i;
  logic                 d_pos;

  assign shamt    = SHIFT_W'(i_q);
  assign atan_idx = 5'(i_q);
  // Narrow the 32-bit angle to this datapath width by arithmetic shift.
  assign atan_i   = BIT_WIDTH'($signed(ATAN_TABLE[atan_idx]) >>> (32 - BIT_WIDTH));

  cordic_iter_shifter #(.BIT_WIDTH(BIT_WIDTH), .SHIFT_W(SHIFT_W)) u_shr_x (
    .data_i   (x_q),
    .shamt_i  (shamt),
    .result_o (x_shr)
  );

  cordic_iter_shifter #(.BIT_WIDTH(BIT_WIDTH), .SHIFT_W(SHIFT_W)) u_shr_y (
    .data_i   (y_q),
    .shamt_i  (shamt),
    .result_o (y_shr)
  );

  // Rotation drives z toward 0; vectoring drives y toward 0.
  assign d_pos = mode_q ? y_q[BIT_WIDTH-1] : ~z_q[BIT_WIDTH-1];

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          mode_d  = mode_in;
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          i_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The extra cycle at i == ITERATIONS publishes the finished vector.
        if (i_q == LAST_I) begin
          xo_d    = x_q;
          yo_d    = y_q;
          zo_d    = z_q;
          state_d = DONE;
        end else begin
          x_d = d_pos ? (x_q - y_shr) : (x_q + y_shr);
          y_d = d_pos ? (y_q + x_shr) : (y_q - x_shr);
          z_d = d_pos ? (z_q - atan_i) : (z_q + atan_i);
          i_d = i_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
    end
  end

  assign ready_out = (state_q == IDLE);
  assign done_out  = (state_q == DONE);
  assign x_out     = xo_q;
  assign y_out     = yo_q;
  assign z_out     = zo_q;

endmodule

// File: tb/tb_cordic_iter.sv
// Self-checking bench for cordic_iter (16-bit, 12 iterations): directed table,
// randomized operations against an integer model, and control corner cases.
module tb_cordic_iter;

  localparam int BW   = 16;
  localparam int N_IT = 12;
  localparam int LAT  = N_IT + 1;
  localparam real PI  = 3.14159265358979;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_in;
  logic          mode_in;
  logic [BW-1:0] x_in, y_in, z_in;
  logic          ready_out, done_out;
  logic [BW-1:0] x_out, y_out, z_out;

  always #5 clk = ~clk;

  cordic_iter #(.BIT_WIDTH(BW), .ITERATIONS(N_IT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_in  (start_in),
    .mode_in   (mode_in),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .ready_out (ready_out),
    .done_out  (done_out),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out)
  );

  int n_cmp = 0;
  int n_err = 0;
  int atan_ref [N_IT];

  typedef struct {
    bit mode;
    int x, y, z;
    int ex, ey, ez;
  } vec_t;

  vec_t vecs [3];

  function automatic int wrap16(input int v);
    return int'(shortint'(v));
  endfunction

  // Plain-integer CORDIC with angles derived from real arctangent.
  function automatic void cordic_ref(input bit mode, input int x0, input int y0, input int z0,
                                     output int xr, output int yr, output int zr);
    int x, y, z, d, xn, yn;
    x = wrap16(x0);
    y = wrap16(y0);
    z = wrap16(z0);
    for (int i = 0; i < N_IT; i++) begin
      if (mode) d = (y < 0) ? 1 : -1;
      else      d = (z >= 0) ? 1 : -1;
      xn = x - d * (y >>> i);
      yn = y + d * (x >>> i);
      z  = wrap16(z - d * atan_ref[i]);
      x  = wrap16(xn);
      y  = wrap16(yn);
    end
    xr = x;
    yr = y;
    zr = z;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    int diff;
    diff = wrap16(act - exp);
    n_cmp++;
    if (diff > tol || diff < -tol) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  function automatic int sx(input logic [BW-1:0] v);
    return int'($signed(v));
  endfunction

  // Caller is just after a negedge with the DUT idle.
  task automatic launch_and_wait(input bit mode, input int x, input int y, input int z,
                                 output int rx, output int ry, output int rz);
    int lat;
    start_in = 1'b1;
    mode_in  = mode;
    x_in     = 16'(x);
    y_in     = 16'(y);
    z_in     = 16'(z);
    @(posedge clk);
    #1;
    start_in = 1'b0;
    chk("accept_ready_low", int'(ready_out), 0);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done_out) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", lat, LAT);
    rx = sx(x_out);
    ry = sx(y_out);
    rz = sx(z_out);
  endtask

  task automatic do_op(input bit mode, input int x, input int y, input int z,
                       output int rx, output int ry, output int rz);
    @(negedge clk);
    for (int k = 0; k < 50 && !ready_out; k++) @(negedge clk);
    launch_and_wait(mode, x, y, z, rx, ry, rz);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx, ry, rz, mx, my, mz, ndone, first, ax, ay, az;
    int lx, ly, lz;
    int qx[$], qy[$], qz[$];
    bit m;
    int x, y, z;

    rst = 1'b1;
    start_in = 1'b0;
    mode_in = 1'b0;
    x_in = '0;
    y_in = '0;
    z_in = '0;

    for (int i = 0; i < N_IT; i++)
      atan_ref[i] = int'($floor($atan(1.0 / (2.0 ** i)) / PI * 32768.0 + 1.0e-6));

    vecs[0] = '{mode: 1'b0, x: 8192, y: 0,    z: 0,      ex: 13491, ey: 0,     ez: 0};
    vecs[1] = '{mode: 1'b0, x: 8192, y: 0,    z: 16384,  ex: 0,     ey: 13491, ez: 0};
    vecs[2] = '{mode: 1'b1, x: 8192, y: 8192, z: 0,      ex: 19078, ey: 0,     ez: 8192};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", int'(ready_out), 1);
    chk("reset_done", int'(done_out), 0);
    chk("reset_x", sx(x_out), 0);
    chk("reset_y", sx(y_out), 0);
    chk("reset_z", sx(z_out), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table with tolerance plus exact model
    for (int v = 0; v < 3; v++) begin
      do_op(vecs[v].mode, vecs[v].x, vecs[v].y, vecs[v].z, rx, ry, rz);
      cordic_ref(vecs[v].mode, vecs[v].x, vecs[v].y, vecs[v].z, mx, my, mz);
      chk_tol($sformatf("vec%0d_x", v), rx, vecs[v].ex, 4);
      chk_tol($sformatf("vec%0d_y", v), ry, vecs[v].ey, 4);
      chk_tol($sformatf("vec%0d_z", v), rz, vecs[v].ez, 2);
      chk($sformatf("vec%0d_x_exact", v), rx, mx);
      chk($sformatf("vec%0d_y_exact", v), ry, my);
      chk($sformatf("vec%0d_z_exact", v), rz, mz);
      $display("vec %0d mode=%0d in=(%0d,%0d,%0d) out=(%0d,%0d,%0d)",
               v, vecs[v].mode, vecs[v].x, vecs[v].y, vecs[v].z, rx, ry, rz);
    end

    // Randomized operations
    for (int t = 0; t < 40; t++) begin
      m = 1'($urandom_range(1, 0));
      x = int'($urandom_range(28000, 0)) - 14000;
      y = int'($urandom_range(28000, 0)) - 14000;
      z = int'($urandom_range(65535, 0));
      do_op(m, x, y, z, rx, ry, rz);
      cordic_ref(m, x, y, z, mx, my, mz);
      chk("rand_x", rx, mx);
      chk("rand_y", ry, my);
      chk("rand_z", rz, wrap16(mz));
      $display("rand %0d mode=%0d in=(%0d,%0d,%0d) out=(%0d,%0d,%0d)", t, m, x, y, wrap16(z), rx, ry, rz);
    end

    // Start pulsed during RUN is ignored
    @(negedge clk);
    for (int k = 0; k < 50 && !ready_out; k++) @(negedge clk);
    start_in = 1'b1;
    mode_in  = 1'b0;
    x_in = 16'(5000);
    y_in = 16'(-3000);
    z_in = 16'h1234;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    ndone = 0;
    first = -1;
    ax = 0; ay = 0; az = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 4) begin
        start_in = 1'b1;
        mode_in  = 1'b1;
        x_in = 16'(1111);
        y_in = 16'(2222);
        z_in = 16'h0777;
      end else begin
        start_in = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done_out) begin
        ndone++;
        if (first < 0) begin
          first = k;
          ax = sx(x_out); ay = sx(y_out); az = sx(z_out);
        end
      end
    end
    cordic_ref(1'b0, 5000, -3000, 32'h1234, mx, my, mz);
    chk("ignore_start_ndone", ndone, 1);
    chk("ignore_start_latency", first, LAT);
    chk("ignore_start_x", ax, mx);
    chk("ignore_start_y", ay, my);
    chk("ignore_start_z", az, mz);
    $display("ignored-start op: dones=%0d out=(%0d,%0d,%0d)", ndone, ax, ay, az);

    // Reset in the 5th RUN cycle aborts the operation
    @(negedge clk);
    for (int k = 0; k < 50 && !ready_out; k++) @(negedge clk);
    start_in = 1'b1;
    mode_in  = 1'b0;
    x_in = 16'(7000);
    y_in = 16'(1000);
    z_in = 16'h2000;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ready", int'(ready_out), 1);
    chk("abort_done", int'(done_out), 0);
    chk("abort_x", sx(x_out), 0);
    chk("abort_y", sx(y_out), 0);
    chk("abort_z", sx(z_out), 0);
    @(posedge clk);
    // Start on the first edge after reset release
    @(negedge clk);
    rst = 1'b0;
    start_in = 1'b1;
    mode_in  = 1'b1;
    x_in = 16'(6000);
    y_in = 16'(-4000);
    z_in = 16'h0100;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    chk("post_reset_accept", int'(ready_out), 0);
    ndone = 0;
    first = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (done_out) begin
        ndone++;
        if (first < 0) begin
          first = k;
          ax = sx(x_out); ay = sx(y_out); az = sx(z_out);
        end
      end
    end
    cordic_ref(1'b1, 6000, -4000, 32'h0100, mx, my, mz);
    chk("post_reset_ndone", ndone, 1);
    chk("post_reset_latency", first, LAT);
    chk("post_reset_x", ax, mx);
    chk("post_reset_y", ay, my);
    chk("post_reset_z", az, mz);
    $display("post-reset op: dones=%0d out=(%0d,%0d,%0d)", ndone, ax, ay, az);

    // Back-to-back with start held high: accept every LAT+2 cycles
    lx = mx; ly = my; lz = mz;
    for (int k = 0; k < 3 * (LAT + 2); k++) begin
      @(negedge clk);
      start_in = 1'b1;
      m = 1'($urandom_range(1, 0));
      x = int'($urandom_range(28000, 0)) - 14000;
      y = int'($urandom_range(28000, 0)) - 14000;
      z = int'($urandom_range(65535, 0));
      mode_in = m;
      x_in = 16'(x);
      y_in = 16'(y);
      z_in = 16'(z);
      chk("b2b_ready", int'(ready_out), (k % (LAT + 2) == 0) ? 1 : 0);
      if (k % (LAT + 2) == 0) begin
        cordic_ref(m, x, y, z, mx, my, mz);
        qx.push_back(mx);
        qy.push_back(my);
        qz.push_back(mz);
      end
      @(posedge clk);
      #1;
      chk("b2b_done", int'(done_out), (k % (LAT + 2) == LAT) ? 1 : 0);
      if (k % (LAT + 2) == LAT && qx.size() > 0) begin
        lx = qx.pop_front();
        ly = qy.pop_front();
        lz = qz.pop_front();
        $display("b2b done at cycle %0d out=(%0d,%0d,%0d)", k, sx(x_out), sx(y_out), sx(z_out));
      end
      chk("b2b_x", sx(x_out), lx);
      chk("b2b_y", sx(y_out), ly);
      chk("b2b_z", sx(z_out), lz);
    end
    start_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_iter.md
CORDIC_ITER -- requirements
Module: cordic_iter

Interface
REQ-001 Parameter BIT_WIDTH, default 16: width of x, y and z data paths; legal range 8..32.
REQ-002 Parameter ITERATIONS, default 12: number of micro-rotations; legal range 1..BIT_WIDTH.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start_in  input  1  request a new operation; sampled only when ready_out=1.
REQ-006 mode_in  input  1  0 = rotation, 1 = vectoring; captured with start_in.
REQ-007 x_in, y_in, z_in  input  BIT_WIDTH each  signed two's-complement operands; captured with start_in.
REQ-008 ready_out  output  1  high when the block accepts start_in.
REQ-009 done_out  output  1  one-cycle pulse when results are valid.
REQ-010 x_out, y_out, z_out  output  BIT_WIDTH each  signed results; held from done_out until the next accepted start.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE; ready_out = (state==IDLE).
REQ-012 IDLE with start_in=1: capture operands and mode, clear iteration counter i, go to RUN.
REQ-013 start_in in RUN or DONE SHALL be ignored; no queuing.
REQ-014 RUN: one micro-rotation per clock for i = 0..ITERATIONS-1, then go to DONE.
REQ-015 DONE SHALL last exactly one cycle with done_out=1, then return to IDLE.
REQ-016 done_out SHALL be high in the cycle after the (ITERATIONS+1)th rising edge following the edge that accepted start_in.
REQ-017 Direction d: rotation mode d=+1 if z>=0, else -1; vectoring mode d=+1 if y<0, else -1.
REQ-018 Update: x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan_i; >>> is arithmetic (sign-filling) shift.
REQ-019 Angle format: binary angle; 2^(BIT_WIDTH-1) represents pi; z wraps modulo 2^BIT_WIDTH.
REQ-020 x/y adds SHALL wrap modulo 2^BIT_WIDTH without saturation; CORDIC gain (~1.6468) SHALL NOT be compensated.
REQ-021 Callers keep |x_in|,|y_in| below 2^(BIT_WIDTH-1)/2.33 to avoid overflow; behaviour outside that range is defined only as wrapped arithmetic.
REQ-022 Outputs x_out, y_out, z_out SHALL update only on the transition into DONE.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE, i=0, ready_out=1, done_out=0 and x_out=y_out=z_out=0.
REQ-024 rst asserted during RUN or DONE SHALL abort the operation; no done_out is produced for it.
REQ-025 start_in on the first rising edge after rst deasserts SHALL be accepted normally.

Structure
REQ-026 Package cordic_pkg SHALL hold the state enum and a 32-entry atan table scaled to 2^31 = pi.
REQ-027 The block SHALL derive the BIT_WIDTH-bit atan entry by arithmetic right shift of the package entry by 32-BIT_WIDTH.
REQ-028 The existing combinational shifter (parameter BIT_WIDTH; data, shift amount, result) SHALL be instantiated twice, once for x>>>i and once for y>>>i.
REQ-029 The iteration counter width SHALL be $clog2(ITERATIONS+1).

Verification (BIT_WIDTH=16, ITERATIONS=12, tolerance +/-4 LSB on x/y and +/-2 LSB on z)
REQ-030 Rotation, x=8192, y=0, z=0 -> x_out~13491, y_out~0, z_out~0; done_out exactly 13 edges after start.
REQ-031 Rotation, x=8192, y=0, z=0x4000 (pi/2) -> x_out~0, y_out~13491, z_out~0.
REQ-032 Vectoring, x=8192, y=8192, z=0 -> x_out~19078, y_out~0, z_out~0x2000 (pi/4).
REQ-033 Pulse start_in again during RUN -> ignored; exactly one done_out; results match the first operands.
REQ-034 Assert rst in the 5th RUN cycle -> all outputs 0 and ready_out=1 immediately; no done_out; next start completes correctly.
REQ-035 Back-to-back: start_in held high -> a new operation is accepted in the IDLE cycle after each DONE; x_out/y_out/z_out stay stable between done pulses.
